fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  in  1  rising-edge clock, sole clock.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: imem_req_valid  out  1  fetch request valid.
REQ-005 SHALL have port: imem_req_ready  in  1  instruction memory accepts request.
REQ-006 SHALL have port: imem_addr  out  32  fetch byte address, word aligned.
REQ-007 SHALL have port: imem_rsp_valid  in  1  instruction word returned, in request order, at least 1 cycle after acceptance.
REQ-008 SHALL have port: imem_rsp_data  in  32  returned instruction word.
REQ-009 SHALL have port: redirect  in  1  taken branch/jump (PCSrc) from execute.
REQ-010 SHALL have port: redirect_pc  in  32  branch/jump target (PCTarget).
REQ-011 SHALL have port: dec_valid  out  1  instruction presented to decode.
REQ-012 SHALL have port: dec_ready  in  1  decode consumes instruction.
REQ-013 SHALL have ports: dec_instr out 32; dec_pc out 32; dec_pcplus4 out 32; dec_op out 7 (= dec_instr[6:0], drives main-decoder op).
REQ-014 SHALL have port: dec_illegal  out  1  opcode not in supported set (see Configuration).

Function
REQ-015 SHALL implement FSM BOOT, RUN, DRAIN; BOOT lasts exactly one cycle after reset release, no request, then RUN.
REQ-016 SHALL hold PC register pc_q; imem_addr = pc_q; request accepted when imem_req_valid && imem_req_ready, then pc_q += 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-017 SHALL keep a 2-entry in-order buffer of {instr, pc}; plus a 2-entry queue of outstanding request addresses.
REQ-018 SHALL assert imem_req_valid only in RUN, without redirect, and while outstanding + buffered < 2 (credit limit 2).
REQ-019 SHALL, on a non-dropped response, pop the oldest outstanding address and push {imem_rsp_data, address} into the buffer; buffer overflow is impossible by REQ-018.
REQ-020 SHALL drive dec_valid = buffer non-empty; head entry on dec_instr/dec_pc; dec_pcplus4 = dec_pc + 4 (wrapping); pop on dec_valid && dec_ready.
REQ-021 SHALL hold all dec_* outputs stable while dec_valid && !dec_ready, except on redirect.
REQ-022 SHALL give response-to-dec_valid latency of exactly 1 cycle when the buffer is empty; buffer push and pop in the same cycle SHALL keep the count unchanged.
REQ-023 SHALL, on redirect (highest priority over every other event in that cycle): pc_q <= {redirect_pc[31:2],2'b00}; buffer cleared (dec_valid 0 next cycle); no request issued that cycle; drop_cnt <= outstanding count after that cycle's response is counted; state <= DRAIN if drop_cnt nonzero else RUN.
REQ-024 SHALL, in DRAIN, discard each response and decrement drop_cnt, issue no requests, return to RUN when drop_cnt reaches 0; redirect in DRAIN SHALL reapply REQ-023.
REQ-025 SHALL ignore imem_rsp_valid when no request is outstanding.

Reset
REQ-026 SHALL, while reset high, asynchronously set pc_q = RESET_PC, state BOOT, buffer/queue empty, drop_cnt 0, imem_req_valid 0, dec_valid 0, dec_instr/dec_pc 0, dec_pcplus4 4, dec_op 0, dec_illegal 0.
REQ-027 SHALL, on reset mid-operation, discard all buffered and outstanding entries; instruction memory shares the reset, so no stale responses follow.

Configuration
REQ-028 SHALL, with FETCH_ILLEGAL_CHECK_EN defined, drive dec_illegal = dec_valid && dec_op not in {0000011, 0100011, 0110011, 1100011, 0010011, 1101111}, registered with the buffer entry; without it dec_illegal is constant 0 and no check logic exists.

Verification
REQ-029 SHALL test boot: reset release, ready held 1, rsp 1 cycle later -> first request at cycle 2, addr RESET_PC, then 0x4, 0x8; dec_pc sequence 0,4,8.
REQ-030 SHALL test backpressure: dec_ready 0 for 5 cycles -> 2 entries buffered, imem_req_valid 0, dec_instr stable; ready 1 -> both drained in order.
REQ-031 SHALL test redirect with 2 outstanding, redirect_pc 0x103 -> next request addr 0x100 after 2 discarded responses; no stale dec_valid.
REQ-032 SHALL test wrap: RESET_PC 0xFFFFFFFC -> second request addr 0x0, dec_pcplus4 0x0.
REQ-033 SHALL test, with FETCH_ILLEGAL_CHECK_EN, instr 0x0000007F -> dec_illegal 1; 0x00000013 -> 0; without macro -> always 0.
REQ-034 SHALL test async reset asserted mid-DRAIN -> all outputs at REQ-026 values in that same cycle, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// In-order instruction fetch: PC register, 2-credit request window, 2-entry decode buffer, redirect drain.
// Define FETCH_ILLEGAL_CHECK_EN to flag opcodes outside the supported subset on dec_illegal.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pcplus4,
  output logic [6:0]  dec_op,
  output logic        dec_illegal
);
  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] oq_addr_q [2];
  logic [31:0] oq_addr_d [2];
  logic [1:0]  oq_cnt_q, oq_cnt_d;
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_instr_d [2];
  logic [31:0] buf_pc_q [2];
  logic [31:0] buf_pc_d [2];
  logic [1:0]  buf_cnt_q, buf_cnt_d;
  logic [1:0]  drop_cnt_q, drop_cnt_d;

  logic [1:0]  out_total, remain, oq_cnt_tmp, buf_cnt_tmp;
  logic        rsp_fire, rsp_keep, rsp_drop, req_fire, dec_pop;

`ifdef FETCH_ILLEGAL_CHECK_EN
  logic buf_ill_q [2];
  logic buf_ill_d [2];
  logic rsp_ill;
  assign rsp_ill = !(imem_rsp_data[6:0] inside {7'b0000011, 7'b0100011, 7'b0110011,
                                                  7'b1100011, 7'b0010011, 7'b1101111});
  assign dec_illegal = dec_valid && buf_ill_q[0];
`else
  assign dec_illegal = 1'b0;
`endif

  // Responses arriving while nothing is in flight are spurious and ignored.
  assign out_total      = oq_cnt_q + drop_cnt_q;
  assign rsp_fire       = imem_rsp_valid && (out_total != 2'd0);
  assign rsp_drop       = rsp_fire && (drop_cnt_q != 2'd0);
  assign rsp_keep       = rsp_fire && (drop_cnt_q == 2'd0);
  assign remain         = out_total - {1'b0, rsp_fire};
  assign imem_req_valid = (state_q == ST_RUN) && !redirect && ((oq_cnt_q + buf_cnt_q) < 2'd2);
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign imem_addr      = pc_q;
  assign dec_valid      = (buf_cnt_q != 2'd0);
  assign dec_pop        = dec_valid && dec_ready;
  assign dec_instr      = buf_instr_q[0];
  assign dec_pc         = buf_pc_q[0];
  assign dec_pcplus4    = buf_pc_q[0] + 32'd4;
  assign dec_op         = buf_instr_q[0][6:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    oq_addr_d   = oq_addr_q;
    oq_cnt_d    = oq_cnt_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_cnt_d   = buf_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    oq_cnt_tmp  = oq_cnt_q;
    buf_cnt_tmp = buf_cnt_q;
`ifdef FETCH_ILLEGAL_CHECK_EN
    buf_ill_d   = buf_ill_q;
`endif
    if (redirect) begin
      // Everything still in flight becomes a response to throw away.
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      oq_cnt_d   = 2'd0;
      buf_cnt_d  = 2'd0;
      drop_cnt_d = remain;
      state_d    = (remain != 2'd0) ? ST_DRAIN : ST_RUN;
    end else begin
      if (rsp_keep) begin
        oq_addr_d[0] = oq_addr_q[1];
        oq_cnt_tmp   = oq_cnt_q - 2'd1;
      end
      if (req_fire) begin
        if (oq_cnt_tmp == 2'd0) oq_addr_d[0] = pc_q;
        else                    oq_addr_d[1] = pc_q;
        oq_cnt_tmp = oq_cnt_tmp + 2'd1;
        pc_d       = pc_q + 32'd4;
      end
      oq_cnt_d = oq_cnt_tmp;

      if (dec_pop) begin
        buf_instr_d[0] = buf_instr_q[1];
        buf_pc_d[0]    = buf_pc_q[1];
`ifdef FETCH_ILLEGAL_CHECK_EN
        buf_ill_d[0]   = buf_ill_q[1];
`endif
        buf_cnt_tmp    = buf_cnt_q - 2'd1;
      end
      if (rsp_keep) begin
        if (buf_cnt_tmp == 2'd0) begin
          buf_instr_d[0] = imem_rsp_data;
          buf_pc_d[0]    = oq_addr_q[0];
`ifdef FETCH_ILLEGAL_CHECK_EN
          buf_ill_d[0]   = rsp_ill;
`endif
        end else begin
          buf_instr_d[1] = imem_rsp_data;
          buf_pc_d[1]    = oq_addr_q[0];
`ifdef FETCH_ILLEGAL_CHECK_EN
          buf_ill_d[1]   = rsp_ill;
`endif
        end
        buf_cnt_tmp = buf_cnt_tmp + 2'd1;
      end
      buf_cnt_d = buf_cnt_tmp;

      if (rsp_drop) drop_cnt_d = drop_cnt_q - 2'd1;
      case (state_q)
        ST_BOOT:  state_d = ST_RUN;
        ST_DRAIN: if (drop_cnt_d == 2'd0) state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_PC;
      oq_addr_q[0]   <= 32'd0;
      oq_addr_q[1]   <= 32'd0;
      oq_cnt_q       <= 2'd0;
      buf_instr_q[0] <= 32'd0;
      buf_instr_q[1] <= 32'd0;
      buf_pc_q[0]    <= 32'd0;
      buf_pc_q[1]    <= 32'd0;
      buf_cnt_q      <= 2'd0;
      drop_cnt_q     <= 2'd0;
`ifdef FETCH_ILLEGAL_CHECK_EN
      buf_ill_q[0]   <= 1'b0;
      buf_ill_q[1]   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      oq_addr_q   <= oq_addr_d;
      oq_cnt_q    <= oq_cnt_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_cnt_q   <= buf_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef FETCH_ILLEGAL_CHECK_EN
      buf_ill_q   <= buf_ill_d;
`endif
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model checked every cycle, in-order memory stub,
// directed boot/backpressure/redirect/wrap/reset scenarios followed by randomized traffic.
module tb_fetch_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        dec_ready = 1'b0;

  logic        imem_req_valid, dec_valid, dec_illegal;
  logic [31:0] imem_addr, dec_instr, dec_pc, dec_pcplus4;
  logic [6:0]  dec_op;
  logic        w_req_valid, w_dec_valid, w_dec_illegal;
  logic [31:0] w_imem_addr, w_dec_instr, w_dec_pc, w_dec_pcplus4;
  logic [6:0]  w_dec_op;

  fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_pcplus4(dec_pcplus4), .dec_op(dec_op), .dec_illegal(dec_illegal)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(w_imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(w_dec_valid), .dec_ready(dec_ready), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc),
    .dec_pcplus4(w_dec_pcplus4), .dec_op(w_dec_op), .dec_illegal(w_dec_illegal)
  );

`ifdef FETCH_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int rdy; } memreq_t;

  // Reference model: fetched-not-returned addresses, decode-visible entries, responses to discard.
  logic [31:0] oq[$];
  ent_t        bq[$];
  int          m_drop;
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_req;

  memreq_t     memq[$];
  bit          rsp_from_mem, acc_dut;
  logic [31:0] acc_addr_dut;
  int          cyc;

  int p_rdy, p_dready, p_rsp, p_redir, lat_max;
  bit spur, force_redir;
  logic [31:0] force_pc;

  int          first_req_cyc;
  logic [31:0] acc_addrs[$], hs_pc[$], hs_instr[$], hs_ill[$], w_acc[$];
  bit          w_seen, obs_req, obs_dv;
  logic [31:0] w_first_p4, obs_instr, obs_pc, obs_addr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    case (a[4:2])
      3'd0: op = 7'h03;
      3'd1: op = 7'h23;
      3'd2: op = 7'h33;
      3'd3: op = 7'h63;
      3'd4: op = 7'h13;
      3'd5: op = 7'h6F;
      3'd6: op = 7'h7F;
      default: op = 7'h37;
    endcase
    return {a[31:7], op};
  endfunction

  function automatic bit op_legal(input logic [6:0] op);
    return op inside {7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h6F};
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check_cycle();
    logic [31:0] hi;
    bit exp_dv;
    m_req  = !m_boot && (m_drop == 0) && !redirect && ((oq.size() + bq.size()) < 2);
    exp_dv = bq.size() > 0;
    chk("req_valid", 32'(imem_req_valid), 32'(m_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("dec_valid", 32'(dec_valid), 32'(exp_dv));
    if (exp_dv) begin
      hi = bq[0].instr;
      chk("dec_instr", dec_instr, hi);
      chk("dec_pc", dec_pc, bq[0].pc);
      chk("dec_pcplus4", dec_pcplus4, bq[0].pc + 32'd4);
      chk("dec_op", 32'(dec_op), 32'(hi[6:0]));
      chk("dec_illegal", 32'(dec_illegal), 32'(ILL_EN && !op_legal(hi[6:0])));
    end else begin
      chk("dec_illegal_idle", 32'(dec_illegal), 32'd0);
    end
    acc_dut      = imem_req_valid && imem_req_ready;
    acc_addr_dut = imem_addr;
    if (imem_req_valid && first_req_cyc == 0) first_req_cyc = cyc;
    if (acc_dut) acc_addrs.push_back(imem_addr);
    if (dec_valid && dec_ready) begin
      hs_pc.push_back(dec_pc);
      hs_instr.push_back(dec_instr);
      hs_ill.push_back(32'(dec_illegal));
    end
    if (w_req_valid && imem_req_ready) w_acc.push_back(w_imem_addr);
    if (w_dec_valid && !w_seen) begin
      w_seen     = 1'b1;
      w_first_p4 = w_dec_pcplus4;
    end
    obs_req   = imem_req_valid;
    obs_addr  = imem_addr;
    obs_dv    = dec_valid;
    obs_instr = dec_instr;
    obs_pc    = dec_pc;
  endtask

  task automatic model_update();
    bit acc, rsp, pop;
    ent_t e;
    acc = m_req && imem_req_ready;
    rsp = imem_rsp_valid && ((oq.size() + m_drop) > 0);
    pop = (bq.size() > 0) && dec_ready;
    if (redirect) begin
      m_drop = oq.size() + m_drop - (rsp ? 1 : 0);
      oq.delete();
      bq.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(bq.pop_front());
      if (rsp) begin
        if (m_drop > 0) m_drop--;
        else begin
          e.instr = imem_rsp_data;
          e.pc    = oq.pop_front();
          bq.push_back(e);
        end
      end
      if (acc) begin
        oq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    m_boot = 1'b0;
  endtask

  task automatic step();
    memreq_t r;
    @(negedge clk);
    imem_req_ready = pct(p_rdy);
    dec_ready      = pct(p_dready);
    if (force_redir) begin
      redirect    = 1'b1;
      redirect_pc = force_pc;
    end else begin
      redirect    = pct(p_redir);
      redirect_pc = $urandom();
    end
    rsp_from_mem   = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom();
    if (memq.size() > 0) begin
      if (memq[0].rdy <= cyc && pct(p_rsp)) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(memq[0].addr);
        rsp_from_mem   = 1'b1;
      end
    end else if (spur && pct(15)) begin
      imem_rsp_valid = 1'b1;
    end
    #1;
    check_cycle();
    @(posedge clk);
    model_update();
    if (rsp_from_mem) void'(memq.pop_front());
    if (acc_dut) begin
      r.addr = acc_addr_dut;
      r.rdy  = cyc + int'($urandom_range(1, lat_max));
      memq.push_back(r);
    end
    cyc++;
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0000_0000);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_dec_pcplus4", dec_pcplus4, 32'd4);
    chk("rst_dec_op", 32'(dec_op), 32'd0);
    chk("rst_dec_illegal", 32'(dec_illegal), 32'd0);
    chk("rst_wrap_imem_addr", w_imem_addr, 32'hFFFF_FFFC);
    chk("rst_wrap_req_valid", 32'(w_req_valid), 32'd0);
    chk("rst_wrap_dec_valid", 32'(w_dec_valid), 32'd0);
    chk("rst_wrap_dec_fields", w_dec_instr | w_dec_pc | 32'(w_dec_op) | 32'(w_dec_illegal), 32'd0);
    chk("rst_wrap_dec_pcplus4", w_dec_pcplus4, 32'd4);
    @(posedge clk);
    @(posedge clk);
    #3;
    memq.delete();
    oq.delete();
    bq.delete();
    m_drop = 0;
    m_boot = 1'b1;
    m_pc   = 32'h0000_0000;
    cyc    = 1;
    reset  = 1'b0;
  endtask

  task automatic set_knobs(input int rdy, input int dr, input int rsp, input int rd, input int lat, input bit sp);
    p_rdy = rdy; p_dready = dr; p_rsp = rsp; p_redir = rd; lat_max = lat; spur = sp;
  endtask

  task automatic quiesce();
    set_knobs(0, 100, 100, 0, 1, 1'b0);
    repeat (8) step();
  endtask

  task automatic test_boot();
    logic [31:0] i7f, ill7f, i13, ill13;
    i7f = 32'hDEAD_BEEF; ill7f = 32'hDEAD_BEEF; i13 = 32'hDEAD_BEEF; ill13 = 32'hDEAD_BEEF;
    first_req_cyc = 0;
    acc_addrs.delete(); hs_pc.delete(); hs_instr.delete(); hs_ill.delete(); w_acc.delete();
    w_seen = 1'b0;
    w_first_p4 = 32'hDEAD_BEEF;
    set_knobs(100, 100, 100, 0, 1, 1'b0);
    repeat (30) step();
    chk("boot_first_req_cycle", 32'(first_req_cyc), 32'd2);
    chk("boot_addr0", q_at(acc_addrs, 0), 32'h0);
    chk("boot_addr1", q_at(acc_addrs, 1), 32'h4);
    chk("boot_addr2", q_at(acc_addrs, 2), 32'h8);
    chk("boot_dec_pc0", q_at(hs_pc, 0), 32'h0);
    chk("boot_dec_pc1", q_at(hs_pc, 1), 32'h4);
    chk("boot_dec_pc2", q_at(hs_pc, 2), 32'h8);
    chk("wrap_addr0", q_at(w_acc, 0), 32'hFFFF_FFFC);
    chk("wrap_addr1", q_at(w_acc, 1), 32'h0);
    chk("wrap_pcplus4", w_first_p4, 32'h0);
    for (int i = 0; i < hs_pc.size(); i++) begin
      if (hs_pc[i] == 32'h18) begin i7f = hs_instr[i]; ill7f = hs_ill[i]; end
      if (hs_pc[i] == 32'h10) begin i13 = hs_instr[i]; ill13 = hs_ill[i]; end
    end
    chk("instr_7f", i7f, 32'h0000_007F);
    chk("illegal_7f", ill7f, 32'(ILL_EN));
    chk("instr_13", i13, 32'h0000_0013);
    chk("illegal_13", ill13, 32'd0);
  endtask

  task automatic test_backpressure();
    logic [31:0] held_instr, held_pc;
    set_knobs(100, 0, 100, 0, 1, 1'b0);
    repeat (3) step();
    chk("bp_dv_held", 32'(obs_dv), 32'd1);
    held_instr = obs_instr;
    held_pc    = obs_pc;
    repeat (2) step();
    chk("bp_req_blocked", 32'(obs_req), 32'd0);
    chk("bp_instr_stable", obs_instr, held_instr);
    chk("bp_pc_stable", obs_pc, held_pc);
    chk("bp_two_buffered", 32'(bq.size()), 32'd2);
    hs_pc.delete();
    p_dready = 100;
    repeat (6) step();
    chk("bp_drain0", q_at(hs_pc, 0), held_pc);
    chk("bp_drain1", q_at(hs_pc, 1), held_pc + 32'd4);
  endtask

  task automatic make_two_outstanding();
    quiesce();
    set_knobs(100, 100, 0, 0, 1, 1'b0);
    repeat (3) step();
    chk("two_outstanding", 32'(memq.size()), 32'd2);
  endtask

  task automatic test_redirect();
    bit saw_dv;
    int req_step;
    logic [31:0] req_addr;
    make_two_outstanding();
    force_redir = 1'b1;
    force_pc    = 32'h0000_0103;
    step();
    force_redir = 1'b0;
    p_rsp       = 100;
    saw_dv = 1'b0; req_step = 0; req_addr = 32'hDEAD_BEEF;
    for (int i = 1; i <= 12 && req_step == 0; i++) begin
      step();
      if (obs_dv) saw_dv = 1'b1;
      if (obs_req) begin
        req_step = i;
        req_addr = obs_addr;
      end
    end
    chk("redir_addr", req_addr, 32'h0000_0100);
    chk("redir_req_step", 32'(req_step), 32'd3);
    chk("redir_no_stale_dv", 32'(saw_dv), 32'd0);
  endtask

  task automatic test_drain_reset();
    make_two_outstanding();
    force_redir = 1'b1;
    force_pc    = 32'h0000_0200;
    step();
    force_redir = 1'b0;
    step();
    chk("drain_no_req", 32'(obs_req), 32'd0);
    chk("drain_no_dv", 32'(obs_dv), 32'd0);
    do_reset();
    test_boot();
  endtask

  initial begin
    force_redir = 1'b0;
    force_pc    = 32'd0;
    cyc         = 0;
    set_knobs(100, 100, 100, 0, 1, 1'b0);
    @(posedge clk);
    do_reset();
    test_boot();
    test_backpressure();
    test_redirect();
    test_drain_reset();
    for (int b = 0; b < 16; b++) begin
      set_knobs(int'($urandom_range(30, 100)), int'($urandom_range(20, 100)),
                int'($urandom_range(30, 100)), int'($urandom_range(0, 8)),
                int'($urandom_range(1, 4)), 1'b1);
      if (b == 8) do_reset();
      repeat (200) step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
